// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, opcodes and fetch-state encoding for the MIPS pipeline
package mips_pkg;
  localparam int NB_INSTR = 32;
  localparam logic [5:0] HALT_OP = 6'b111111;
  localparam logic [NB_INSTR-1:0] NOP = 32'h0;
  typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, HALTED = 2'd2} fetch_state_t;
  function automatic logic is_halt(input logic [NB_INSTR-1:0] w);
    return w[NB_INSTR-1 -: 6] == HALT_OP;
  endfunction
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: control, load and IF/ID signals between the fetch stage and its neighbours
// inputs to fetch: enable, stall_i, flush_i, load_en_i, load_data_i, pc_i
// outputs from fetch: instr_o, pc_plus4_o, valid_o, pc_enable_o, load_done_o, halt_o
interface instruction_fetch_if import mips_pkg::*; #(parameter int NB_ADDR = 7);
  logic enable;
  logic stall_i;
  logic flush_i;
  logic load_en_i;
  logic [NB_INSTR-1:0] load_data_i;
  logic [NB_ADDR-1:0] pc_i;
  logic [NB_INSTR-1:0] instr_o;
  logic [NB_ADDR-1:0] pc_plus4_o;
  logic valid_o;
  logic pc_enable_o;
  logic load_done_o;
  logic halt_o;
  modport master (
    output enable, stall_i, flush_i, load_en_i, load_data_i, pc_i,
    input instr_o, pc_plus4_o, valid_o, pc_enable_o, load_done_o, halt_o
  );
  modport slave (
    input enable, stall_i, flush_i, load_en_i, load_data_i, pc_i,
    output instr_o, pc_plus4_o, valid_o, pc_enable_o, load_done_o, halt_o
  );
endinterface

// File: rtl/instr_mem.sv
// instr_mem: instruction word array, synchronous write port, asynchronous read port
// ports: clock, we/waddr/wdata (write), raddr/rdata (combinational read)
module instr_mem import mips_pkg::*; #(parameter int AW = 5) (
  input  logic clock,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [NB_INSTR-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [NB_INSTR-1:0] rdata
);
  logic [NB_INSTR-1:0] mem [2**AW];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with preloadable instruction memory, IF/ID latch and PC enable
// ports: clock, reset (async, active-high), bus (instruction_fetch_if.slave)
module instruction_fetch import mips_pkg::*; #(parameter int NB_ADDR = 7) (
  input logic clock,
  input logic reset,
  instruction_fetch_if.slave bus
);
  localparam int AW = NB_ADDR - 2;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_RUN = RUN;
  localparam logic [1:0] S_HALT = HALTED;
  logic [1:0] state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_INSTR-1:0] instr_q, instr_d, rd_word;
  logic [NB_ADDR-1:0] pc4_q, pc4_d;
  logic valid_q, valid_d, done_q, done_d, halt_q, halt_d;
  logic mem_we, load_last, flush, fetch, fetch_halt;
  logic unused_pc;
  assign unused_pc = ^bus.pc_i[1:0];
  assign mem_we = state_q == S_LOAD && bus.load_en_i;
  assign flush = state_q == S_RUN && bus.flush_i;
  assign fetch = state_q == S_RUN && !bus.flush_i && !bus.stall_i && bus.enable;
  instr_mem #(.AW(AW)) u_mem (
    .clock(clock),
    .we(mem_we),
    .waddr(wr_ptr_q),
    .wdata(bus.load_data_i),
    .raddr(bus.pc_i[NB_ADDR-1:2]),
    .rdata(rd_word)
  );
  // loading stops at a HALT word or at the last slot; the pointer never wraps
  always_comb begin
    load_last = mem_we && (is_halt(bus.load_data_i) || &wr_ptr_q);
    fetch_halt = fetch && is_halt(rd_word);
    wr_ptr_d = mem_we && !(&wr_ptr_q) ? wr_ptr_q + 1'b1 : wr_ptr_q;
    done_d = done_q | load_last;
    instr_d = flush ? NOP : fetch ? rd_word : instr_q;
    valid_d = flush ? 1'b0 : fetch ? 1'b1 : valid_q;
    pc4_d = fetch ? bus.pc_i + NB_ADDR'(4) : pc4_q;
    halt_d = halt_q | fetch_halt;
    state_d = load_last ? S_RUN : fetch_halt ? S_HALT : state_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_LOAD;
      wr_ptr_q <= '0;
      instr_q <= NOP;
      pc4_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
      done_q <= done_d;
      halt_q <= halt_d;
    end
  assign bus.instr_o = instr_q;
  assign bus.pc_plus4_o = pc4_q;
  assign bus.valid_o = valid_q;
  assign bus.load_done_o = done_q;
  assign bus.halt_o = halt_q;
  assign bus.pc_enable_o = state_q == S_RUN && bus.enable && !bus.stall_i && !halt_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table vectors, directed corner sequences and random run against a reference model
module tb_instruction_fetch;
  import mips_pkg::*;
  localparam int M_LOAD = 0, M_RUN = 1, M_HALTED = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  instruction_fetch_if #(.NB_ADDR(7)) bus();
  instruction_fetch #(.NB_ADDR(7)) dut (.clock(clock), .reset(reset), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [31:0] m_mem [32];
  int m_state, m_ptr;
  logic [31:0] m_instr;
  logic [6:0] m_pc4;
  logic m_valid, m_done, m_halt;
  typedef struct {
    bit en, st, fl;
    logic [6:0] pc;
    bit pcen;
    logic [31:0] instr;
    logic [6:0] pc4;
    bit valid, halt;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit en, input bit st, input bit fl, input bit ld,
                       input logic [31:0] d, input logic [6:0] pc);
    bus.enable = en;
    bus.stall_i = st;
    bus.flush_i = fl;
    bus.load_en_i = ld;
    bus.load_data_i = d;
    bus.pc_i = pc;
  endtask

  task automatic model_reset();
    m_state = M_LOAD;
    m_ptr = 0;
    m_instr = 0;
    m_pc4 = 0;
    m_valid = 0;
    m_done = 0;
    m_halt = 0;
  endtask

  function automatic logic model_pcen();
    return m_state == M_RUN && bus.enable && !bus.stall_i && !m_halt;
  endfunction

  task automatic model_step();
    if (m_state == M_LOAD) begin
      if (bus.load_en_i) begin
        m_mem[m_ptr] = bus.load_data_i;
        if (bus.load_data_i[31:26] == 6'h3f || m_ptr == 31) begin
          m_state = M_RUN;
          m_done = 1;
        end else m_ptr++;
      end
    end else if (m_state == M_RUN) begin
      if (bus.flush_i) begin
        m_instr = 0;
        m_valid = 0;
      end else if (bus.enable && !bus.stall_i) begin
        m_instr = m_mem[int'(bus.pc_i) / 4];
        m_pc4 = 7'((int'(bus.pc_i) + 4) % 128);
        m_valid = 1;
        if (m_instr[31:26] == 6'h3f) begin
          m_halt = 1;
          m_state = M_HALTED;
        end
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "_instr"}, bus.instr_o, m_instr);
    check({tag, "_pc4"}, 32'(bus.pc_plus4_o), 32'(m_pc4));
    check({tag, "_valid"}, 32'(bus.valid_o), 32'(m_valid));
    check({tag, "_done"}, 32'(bus.load_done_o), 32'(m_done));
    check({tag, "_halt"}, 32'(bus.halt_o), 32'(m_halt));
  endtask

  task automatic tick();
    #1;
    check("pc_enable", 32'(bus.pc_enable_o), 32'(model_pcen()));
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    cmp_model(tag);
    check({tag, "_pcen"}, 32'(bus.pc_enable_o), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] fill_word(input int i);
    return {6'(i), 26'h0ABCD + 26'(i)};
  endfunction

  initial begin
    tbl[0] = '{1, 0, 0, 7'd0, 1, 32'h20010005, 7'd4, 1, 0};
    tbl[1] = '{1, 1, 0, 7'd4, 0, 32'h20010005, 7'd4, 1, 0};
    tbl[2] = '{1, 1, 0, 7'd4, 0, 32'h20010005, 7'd4, 1, 0};
    tbl[3] = '{0, 0, 0, 7'd4, 0, 32'h20010005, 7'd4, 1, 0};
    tbl[4] = '{1, 0, 0, 7'd4, 1, 32'h20020003, 7'd8, 1, 0};
    tbl[5] = '{1, 1, 1, 7'd8, 0, 32'h00000000, 7'd8, 0, 0};
    tbl[6] = '{1, 0, 0, 7'd8, 1, 32'hFC000000, 7'd12, 1, 1};
    tbl[7] = '{1, 0, 0, 7'd0, 0, 32'hFC000000, 7'd12, 1, 1};
    drive(1, 0, 0, 0, 0, 0);
    apply_reset("reset0");
    drive(1, 1, 1, 0, 0, 7'd8);
    tick();
    cmp_model("load_ignores_ctl");
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 1, fill_word(i), 0);
      tick();
      check($sformatf("fill%0d_done", i), 32'(bus.load_done_o), 32'(i == 31));
    end
    drive(0, 0, 0, 1, 32'hFC000001, 0);
    tick();
    cmp_model("extra_load");
    drive(1, 0, 0, 0, 0, 7'd124);
    tick();
    check("wrap_instr", bus.instr_o, fill_word(31));
    check("wrap_pc4", 32'(bus.pc_plus4_o), 32'd0);
    check("wrap_valid", 32'(bus.valid_o), 32'd1);
    drive(1, 0, 0, 0, 0, 7'd0);
    tick();
    check("word0_kept", bus.instr_o, fill_word(0));
    apply_reset("reset1");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, i == 0 ? 32'h20010005 : i == 1 ? 32'h20020003 : 32'hFC000000, 0);
      tick();
      check($sformatf("prog%0d_done", i), 32'(bus.load_done_o), 32'(i == 2));
    end
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].en, tbl[i].st, tbl[i].fl, 0, 0, tbl[i].pc);
      #1;
      check($sformatf("tbl%0d_pcen", i), 32'(bus.pc_enable_o), 32'(tbl[i].pcen));
      tick();
      check($sformatf("tbl%0d_instr", i), bus.instr_o, tbl[i].instr);
      check($sformatf("tbl%0d_pc4", i), 32'(bus.pc_plus4_o), 32'(tbl[i].pc4));
      check($sformatf("tbl%0d_valid", i), 32'(bus.valid_o), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_halt", i), 32'(bus.halt_o), 32'(tbl[i].halt));
    end
    drive(1, 0, 0, 1, 32'h12345678, 7'd4);
    tick();
    cmp_model("halted_hold");
    apply_reset("reset2");
    drive(0, 0, 0, 1, 32'hFC000000, 0);
    tick();
    check("halt_load_done", 32'(bus.load_done_o), 32'd1);
    drive(1, 0, 0, 0, 0, 7'd4);
    tick();
    check("retained_instr", bus.instr_o, 32'h20020003);
    check("retained_valid", 32'(bus.valid_o), 32'd1);
    #2;
    apply_reset("async_reset");
    for (int r = 0; r < 8; r++) begin
      int k;
      k = $urandom_range(1, 40);
      for (int j = 0; j < k; j++) begin
        logic [31:0] d;
        d = $urandom;
        if ($urandom_range(0, 5) == 0) d[31:26] = 6'h3f;
        drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 9) < 7, d, 7'($urandom));
        tick();
        cmp_model("rnd_load");
      end
      for (int j = 0; j < 60; j++) begin
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 19) < 3,
              $urandom_range(0, 1), $urandom, 7'($urandom));
        tick();
        cmp_model("rnd_run");
      end
      apply_reset("rnd_reset");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
